// File: rtl/ctrl_defs_pkg.sv
// Shared encodings for the multicycle controller sequencer: state
// encoding, datapath select constants, ALU op codes and cmd codes.
package ctrl_defs;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

endpackage

// File: rtl/ctrl_fsm_alu_decoder.sv
// alu_decoder: combinational data-processing cmd decode.
// Ports: funct[4:0] in (cmd + S); alu_control, flag_w, cmd_valid,
// is_cmp out. Macro CTRL_CMP_EN adds CMP (SUB, flags only).
module alu_decoder
    import ctrl_defs::*;
(
    input  logic [4:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       cmd_valid,
    output logic       is_cmp
);

    logic [3:0] cmd;
    logic       s_bit;
    logic       arith;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);

    always_comb begin
        alu_control = ALU_ADD;
        cmd_valid   = 1'b0;
        is_cmp      = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_control = ALU_ADD; cmd_valid = 1'b1; end
            CMD_SUB: begin alu_control = ALU_SUB; cmd_valid = 1'b1; end
            CMD_AND: begin alu_control = ALU_AND; cmd_valid = 1'b1; end
            CMD_ORR: begin alu_control = ALU_ORR; cmd_valid = 1'b1; end
`ifdef CTRL_CMP_EN
            CMD_CMP: begin
                alu_control = ALU_SUB;
                cmd_valid   = 1'b1;
                is_cmp      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // CMP always writes both flag groups, independent of S.
    assign flag_w[1] = s_bit | is_cmp;
    assign flag_w[0] = (s_bit & arith) | is_cmp;

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle Moore sequencer driving datapath selects and
// unconditioned write requests. Inputs clk, reset (sync, high), Op,
// Funct, Rd; outputs IRWrite, AdrSrc, ALUSrcA/B, ResultSrc,
// ALUControl, NextPC, RegW, MemW, PCS, FlagW. Macro: CTRL_CMP_EN.
module ctrl_fsm
    import ctrl_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW
);

    state_t     state, state_next;
    logic [1:0] dec_alu;
    logic [1:0] dec_flag;
    logic       dec_valid;
    logic       dec_cmp;
    logic       rd_pc;

    alu_decoder u_dec (
        .funct       (Funct[4:0]),
        .alu_control (dec_alu),
        .flag_w      (dec_flag),
        .cmd_valid   (dec_valid),
        .is_cmp      (dec_cmp)
    );

    assign rd_pc = (Rd == 4'b1111);

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = dec_cmp ? S_FETCH : S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        PCS        = 1'b0;
        FlagW      = 2'b00;
        if (reset) begin
            // FETCH selects, but no write request may escape.
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
        end else begin
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                end
                S_DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                end
                S_MEMADR: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = Funct[4] ? ALU_ADD : ALU_SUB;
                end
                S_MEMRD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegW      = 1'b1;
                    PCS       = rd_pc;
                end
                S_MEMWR: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                S_EXECR: begin
                    ALUControl = dec_alu;
                    FlagW      = dec_flag;
                end
                S_EXECI: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = dec_alu;
                    FlagW      = dec_flag;
                end
                // Funct is held by the IR, so the decode is still valid.
                S_ALUWB: begin
                    RegW = dec_valid;
                    PCS  = rd_pc;
                end
                S_BRANCH: begin
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURES;
                    PCS       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: per-cycle expected output vectors
// are queued by the stimulus and checked by a negedge monitor.
module tb_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, PCS;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;

    typedef logic [14:0] vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .PCS(PCS), .FlagW(FlagW)
    );

    always #5 clk = ~clk;

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,
    //  NextPC,RegW,MemW,PCS,FlagW}
    function automatic vec_t v(input logic irw, input logic adr,
                               input logic sa, input logic [1:0] sb,
                               input logic [1:0] rs,
                               input logic [1:0] alu,
                               input logic npc, input logic rw,
                               input logic mw, input logic pcs,
                               input logic [1:0] fw);
        return {irw, adr, sa, sb, rs, alu, npc, rw, mw, pcs, fw};
    endfunction

    vec_t actual;
    assign actual = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                     ALUControl, NextPC, RegW, MemW, PCS, FlagW};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (actual !== e) begin
                miscompares++;
                $display("FAIL %s: got %015b expected %015b", n,
                         actual, e);
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] op,
                        input logic [5:0] fn, input logic [3:0] rd,
                        input vec_t e, input string n);
        reset = r;
        Op    = op;
        Funct = fn;
        Rd    = rd;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    vec_t V_RST, V_FETCH, V_DEC, V_ZERO;

    initial begin
        V_RST   = v(0,0,1,2'b10,2'b10,2'b00,0,0,0,0,2'b00);
        V_FETCH = v(1,0,1,2'b10,2'b10,2'b00,1,0,0,0,2'b00);
        V_DEC   = v(0,0,1,2'b10,2'b10,2'b00,0,0,0,0,2'b00);
        V_ZERO  = v(0,0,0,2'b00,2'b00,2'b00,0,0,0,0,2'b00);

        reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'b0;
        @(posedge clk);
        #1;

        step(1, 2'b00, 6'b0, 4'd0, V_RST, "reset0");
        step(1, 2'b00, 6'b0, 4'd0, V_RST, "reset1");

        // ADDS R1,R2,R3
        step(0, 2'b00, 6'b001001, 4'd1, V_FETCH, "adds_fetch");
        step(0, 2'b00, 6'b001001, 4'd1, V_DEC, "adds_decode");
        step(0, 2'b00, 6'b001001, 4'd1,
             v(0,0,0,2'b00,2'b00,2'b00,0,0,0,0,2'b11), "adds_execr");
        step(0, 2'b00, 6'b001001, 4'd1,
             v(0,0,0,2'b00,2'b00,2'b00,0,1,0,0,2'b00), "adds_aluwb");

        // LDR PC, U=1
        step(0, 2'b01, 6'b011001, 4'd15, V_FETCH, "ldr_fetch");
        step(0, 2'b01, 6'b011001, 4'd15, V_DEC, "ldr_decode");
        step(0, 2'b01, 6'b011001, 4'd15,
             v(0,0,0,2'b01,2'b00,2'b00,0,0,0,0,2'b00), "ldr_memadr");
        step(0, 2'b01, 6'b011001, 4'd15,
             v(0,1,0,2'b00,2'b00,2'b00,0,0,0,0,2'b00), "ldr_memrd");
        step(0, 2'b01, 6'b011001, 4'd15,
             v(0,0,0,2'b00,2'b01,2'b00,0,1,0,1,2'b00), "ldr_memwb");

        // STR, U=0 -> SUB address
        step(0, 2'b01, 6'b000000, 4'd2, V_FETCH, "str_fetch");
        step(0, 2'b01, 6'b000000, 4'd2, V_DEC, "str_decode");
        step(0, 2'b01, 6'b000000, 4'd2,
             v(0,0,0,2'b01,2'b00,2'b01,0,0,0,0,2'b00), "str_memadr");
        step(0, 2'b01, 6'b000000, 4'd2,
             v(0,1,0,2'b00,2'b00,2'b00,0,0,1,0,2'b00), "str_memwr");

        // B
        step(0, 2'b10, 6'b100000, 4'd0, V_FETCH, "b_fetch");
        step(0, 2'b10, 6'b100000, 4'd0, V_DEC, "b_decode");
        step(0, 2'b10, 6'b100000, 4'd0,
             v(0,0,0,2'b01,2'b10,2'b00,0,0,0,1,2'b00), "b_branch");

        // Illegal opcode
        step(0, 2'b11, 6'b001001, 4'd15, V_FETCH, "ill_fetch");
        step(0, 2'b11, 6'b001001, 4'd15, V_DEC, "ill_decode");
        step(0, 2'b11, 6'b001001, 4'd15, V_ZERO, "ill_unknown");

        // SUB immediate to PC, S=0
        step(0, 2'b00, 6'b100100, 4'd15, V_FETCH, "subi_fetch");
        step(0, 2'b00, 6'b100100, 4'd15, V_DEC, "subi_decode");
        step(0, 2'b00, 6'b100100, 4'd15,
             v(0,0,0,2'b01,2'b00,2'b01,0,0,0,0,2'b00), "subi_execi");
        step(0, 2'b00, 6'b100100, 4'd15,
             v(0,0,0,2'b00,2'b00,2'b00,0,1,0,1,2'b00), "subi_aluwb");

        // ORRS: NZ only
        step(0, 2'b00, 6'b011001, 4'd3, V_FETCH, "orrs_fetch");
        step(0, 2'b00, 6'b011001, 4'd3, V_DEC, "orrs_decode");
        step(0, 2'b00, 6'b011001, 4'd3,
             v(0,0,0,2'b00,2'b00,2'b11,0,0,0,0,2'b10), "orrs_execr");
        step(0, 2'b00, 6'b011001, 4'd3,
             v(0,0,0,2'b00,2'b00,2'b00,0,1,0,0,2'b00), "orrs_aluwb");

        // AND, S=0
        step(0, 2'b00, 6'b000000, 4'd4, V_FETCH, "and_fetch");
        step(0, 2'b00, 6'b000000, 4'd4, V_DEC, "and_decode");
        step(0, 2'b00, 6'b000000, 4'd4,
             v(0,0,0,2'b00,2'b00,2'b10,0,0,0,0,2'b00), "and_execr");
        step(0, 2'b00, 6'b000000, 4'd4,
             v(0,0,0,2'b00,2'b00,2'b00,0,1,0,0,2'b00), "and_aluwb");

        // Unsupported cmd 0001: RegW suppressed
        step(0, 2'b00, 6'b000010, 4'd5, V_FETCH, "eor_fetch");
        step(0, 2'b00, 6'b000010, 4'd5, V_DEC, "eor_decode");
        step(0, 2'b00, 6'b000010, 4'd5, V_ZERO, "eor_execr");
        step(0, 2'b00, 6'b000010, 4'd5, V_ZERO, "eor_aluwb");

        // CMP with S=1
        step(0, 2'b00, 6'b010101, 4'd0, V_FETCH, "cmp_fetch");
        step(0, 2'b00, 6'b010101, 4'd0, V_DEC, "cmp_decode");
`ifdef CTRL_CMP_EN
        step(0, 2'b00, 6'b010101, 4'd0,
             v(0,0,0,2'b00,2'b00,2'b01,0,0,0,0,2'b11), "cmp_execr");
`else
        step(0, 2'b00, 6'b010101, 4'd0,
             v(0,0,0,2'b00,2'b00,2'b00,0,0,0,0,2'b10), "cmp_execr");
        step(0, 2'b00, 6'b010101, 4'd0, V_ZERO, "cmp_aluwb");
`endif

        // STR interrupted by reset in MEMWR
        step(0, 2'b01, 6'b010000, 4'd2, V_FETCH, "rst_fetch");
        step(0, 2'b01, 6'b010000, 4'd2, V_DEC, "rst_decode");
        step(0, 2'b01, 6'b010000, 4'd2,
             v(0,0,0,2'b01,2'b00,2'b00,0,0,0,0,2'b00), "rst_memadr");
        step(1, 2'b01, 6'b010000, 4'd2, V_RST, "rst_in_memwr");
        step(0, 2'b01, 6'b010000, 4'd2, V_FETCH, "rst_refetch");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left, expected 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
